// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between an execute unit (0) and an aux unit (1).
// One op in flight: grant in IDLE, hold ALU inputs for ALU_LAT cycles in EXEC, present result in RESP.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int OPW     = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [1:0]       req_usecf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_acc,
    output logic [WIDTH-1:0] rsp_c,
    output logic [2:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cf,
    input  logic [WIDTH-1:0] alu_acc,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_c_flag,
    input  logic             alu_z_flag,
    input  logic             alu_o_flag,
    output logic [2:0]       flags_q,
    output logic             busy
);

    localparam int CW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             cf_q, cf_d;
    logic             id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_acc_q, rsp_acc_d, rsp_c_q, rsp_c_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic [2:0]       flags_d;
    logic             grant;
    logic             gnt_id;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cf_d        = cf_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_acc_d   = rsp_acc_q;
        rsp_c_d     = rsp_c_q;
        rsp_flags_d = rsp_flags_q;
        flags_d     = flags_q;
        grant       = 1'b0;
        gnt_id      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // The pointer only moves when it actually settled a tie.
                    gnt_id = (req_valid == 2'b11) ? rr_q : req_valid[1];
                    if (req_valid == 2'b11) rr_d = ~rr_q;
                    grant   = 1'b1;
                    a_d     = gnt_id ? req1_a  : req0_a;
                    b_d     = gnt_id ? req1_b  : req0_b;
                    op_d    = gnt_id ? req1_op : req0_op;
                    cf_d    = req_usecf[gnt_id] & flags_q[0];
                    id_d    = gnt_id;
                    cnt_d   = CW'(ALU_LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_acc_d   = alu_acc;
                    rsp_c_d     = alu_c;
                    rsp_flags_d = {alu_o_flag, alu_z_flag, alu_c_flag};
                    flags_d     = {alu_o_flag, alu_z_flag, alu_c_flag};
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cf_q        <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_acc_q   <= '0;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cf_q        <= cf_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_acc_q   <= rsp_acc_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flags_q <= rsp_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign req_ready = (grant && !rst) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_acc   = rsp_acc_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_flags = rsp_flags_q;
    // ALU sees zeros whenever no op is in flight.
    assign alu_a     = (state_q == EXEC) ? a_q  : '0;
    assign alu_b     = (state_q == EXEC) ? b_q  : '0;
    assign alu_op    = (state_q == EXEC) ? op_q : '0;
    assign alu_cf    = (state_q == EXEC) ? cf_q : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives two arbiters (ALU_LAT 1 and 3) with identical random traffic and compares each
// cycle against a transaction-level model of grants, ALU hold time, captured results and flags.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0]  req0_op, req1_op;
    logic [1:0]  req_usecf;
    logic        rsp_ready;

    logic [1:0]  rdy_w   [2];
    logic        rv_w    [2];
    logic        rid_w   [2];
    logic [15:0] racc_w  [2];
    logic [15:0] rc_w    [2];
    logic [2:0]  rfl_w   [2];
    logic [15:0] aa_w    [2];
    logic [15:0] ab_w    [2];
    logic [7:0]  aop_w   [2];
    logic        acf_w   [2];
    logic [15:0] xacc_w  [2];
    logic [15:0] xc_w    [2];
    logic        xcf_w   [2];
    logic        xzf_w   [2];
    logic        xof_w   [2];
    logic [2:0]  fl_w    [2];
    logic        busy_w  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bench ALU: returns {o,z,c, acc[15:0], c_res[15:0]}.
    function automatic logic [34:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [7:0] op, logic cf);
        logic [16:0] s;
        logic [15:0] cr;
        if (op[0]) s = {1'b0, a} - {1'b0, b} - {16'b0, cf};
        else       s = {1'b0, a} + {1'b0, b} + {16'b0, cf};
        cr = a ^ b ^ {op, op};
        return {(^op) ^ s[15], (s[15:0] == 16'h0), s[16], s[15:0], cr};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(.WIDTH(16), .OPW(8), .ALU_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (rdy_w[g]),
            .req0_a     (req0_a),
            .req0_b     (req0_b),
            .req0_op    (req0_op),
            .req1_a     (req1_a),
            .req1_b     (req1_b),
            .req1_op    (req1_op),
            .req_usecf  (req_usecf),
            .rsp_valid  (rv_w[g]),
            .rsp_ready  (rsp_ready),
            .rsp_id     (rid_w[g]),
            .rsp_acc    (racc_w[g]),
            .rsp_c      (rc_w[g]),
            .rsp_flags  (rfl_w[g]),
            .alu_a      (aa_w[g]),
            .alu_b      (ab_w[g]),
            .alu_op     (aop_w[g]),
            .alu_cf     (acf_w[g]),
            .alu_acc    (xacc_w[g]),
            .alu_c      (xc_w[g]),
            .alu_c_flag (xcf_w[g]),
            .alu_z_flag (xzf_w[g]),
            .alu_o_flag (xof_w[g]),
            .flags_q    (fl_w[g]),
            .busy       (busy_w[g])
        );
        assign {xof_w[g], xzf_w[g], xcf_w[g], xacc_w[g], xc_w[g]} =
            alu_fn(aa_w[g], ab_w[g], aop_w[g], acf_w[g]);
    end

    // Transaction-level model: phase 0 idle, 1 waiting on ALU, 2 holding a result.
    typedef struct {
        int          phase;
        int          left;
        logic [15:0] a, b;
        logic [7:0]  op;
        logic        cf, id, pref;
        logic [2:0]  flags;
        logic [15:0] racc, rc;
        logic [2:0]  rfl;
    } mdl_t;

    mdl_t m [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.phase = 0; r.left = 0; r.a = '0; r.b = '0; r.op = '0; r.cf = 1'b0; r.id = 1'b0;
        r.pref = 1'b0; r.flags = '0; r.racc = '0; r.rc = '0; r.rfl = '0;
        return r;
    endfunction

    function automatic logic pick(logic [1:0] v, logic pref);
        return (v == 2'b11) ? pref : v[1];
    endfunction

    task automatic check_inst(input int g);
        logic [1:0] er;
        string      p;
        p  = (g == 0) ? "lat1" : "lat3";
        er = 2'b00;
        if (m[g].phase == 0 && !rst && req_valid != 2'b00)
            er = pick(req_valid, m[g].pref) ? 2'b10 : 2'b01;
        check({p, ".req_ready"}, 32'(rdy_w[g]), 32'(er));
        check({p, ".busy"},      32'(busy_w[g]), 32'(m[g].phase != 0));
        check({p, ".rsp_valid"}, 32'(rv_w[g]),   32'(m[g].phase == 2));
        check({p, ".rsp_id"},    32'(rid_w[g]),  32'(m[g].id));
        check({p, ".rsp_acc"},   32'(racc_w[g]), 32'(m[g].racc));
        check({p, ".rsp_c"},     32'(rc_w[g]),   32'(m[g].rc));
        check({p, ".rsp_flags"}, 32'(rfl_w[g]),  32'(m[g].rfl));
        check({p, ".flags_q"},   32'(fl_w[g]),   32'(m[g].flags));
        check({p, ".alu_a"},     32'(aa_w[g]),   (m[g].phase == 1) ? 32'(m[g].a)  : 32'd0);
        check({p, ".alu_b"},     32'(ab_w[g]),   (m[g].phase == 1) ? 32'(m[g].b)  : 32'd0);
        check({p, ".alu_op"},    32'(aop_w[g]),  (m[g].phase == 1) ? 32'(m[g].op) : 32'd0);
        check({p, ".alu_cf"},    32'(acf_w[g]),  (m[g].phase == 1) ? 32'(m[g].cf) : 32'd0);
    endtask

    task automatic step_model(input int g);
        logic [34:0] r;
        logic        id;
        int          lat;
        lat = (g == 0) ? 1 : 3;
        if (rst) begin
            m[g] = mdl_reset();
        end else if (m[g].phase == 0) begin
            if (req_valid != 2'b00) begin
                id = pick(req_valid, m[g].pref);
                if (req_valid == 2'b11) m[g].pref = ~m[g].pref;
                m[g].id    = id;
                m[g].a     = id ? req1_a  : req0_a;
                m[g].b     = id ? req1_b  : req0_b;
                m[g].op    = id ? req1_op : req0_op;
                m[g].cf    = req_usecf[id] ? m[g].flags[0] : 1'b0;
                m[g].left  = lat;
                m[g].phase = 1;
            end
        end else if (m[g].phase == 1) begin
            m[g].left--;
            if (m[g].left == 0) begin
                r            = alu_fn(m[g].a, m[g].b, m[g].op, m[g].cf);
                m[g].rfl     = r[34:32];
                m[g].flags   = r[34:32];
                m[g].racc    = r[31:16];
                m[g].rc      = r[15:0];
                m[g].phase   = 2;
            end
        end else if (rsp_ready) begin
            m[g].phase = 0;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_usecf = '0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (2) @(posedge clk);
        m[0] = mdl_reset();
        m[1] = mdl_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            req0_a  = 16'($urandom); req0_b = 16'($urandom); req0_op = 8'($urandom);
            req1_a  = 16'($urandom); req1_b = 16'($urandom); req1_op = 8'($urandom);
            req_usecf = 2'($urandom);
            if (cyc < 60) begin
                // Saturated contention with a free-running consumer.
                rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
            end else if (cyc < 120) begin
                // Long consumer stalls.
                rst = 1'b0; req_valid = 2'($urandom); rsp_ready = ($urandom_range(0, 5) == 0);
            end else begin
                rst       = ($urandom_range(0, 49) == 0);
                req_valid = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
                rsp_ready = ($urandom_range(0, 9) < 7);
            end
            #1;
            check_inst(0);
            check_inst(1);
            step_model(0);
            step_model(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
